// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer for a small LEGv8-style datapath: walks
// FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and counts retirements.
module pc_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      opcode,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             reg_write,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_RSV5   = 3'd5,
    ST_RSV6   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE, CL_B, CL_CBZ, CL_CBNZ, CL_LDUR, CL_STUR, CL_RTYPE, CL_ILLEGAL
  } class_t;

  state_t           r_state;
  state_t           w_next;
  class_t           r_class;
  class_t           w_class;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  always_comb begin
    w_class = CL_ILLEGAL;
    if (opcode[10:5] == 6'b000101)      w_class = CL_B;
    else if (opcode[10:3] == 8'hB4)     w_class = CL_CBZ;
    else if (opcode[10:3] == 8'hB5)     w_class = CL_CBNZ;
    else if (opcode == 11'h7C2)         w_class = CL_LDUR;
    else if (opcode == 11'h7C0)         w_class = CL_STUR;
    else if (opcode inside {11'h458, 11'h658, 11'h450, 11'h550}) w_class = CL_RTYPE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_class   <= CL_NONE;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_class <= w_class;
        if (w_class == CL_ILLEGAL) r_illegal <= 1'b1;
      end
      if (pc_write) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (imem_ready) w_next = ST_DECODE;
      ST_DECODE: w_next = (w_class == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (r_class)
          CL_RTYPE:         w_next = ST_WB;
          CL_LDUR, CL_STUR: w_next = ST_MEM;
          default:          w_next = ST_FETCH;
        endcase
      end
      ST_MEM:    if (dmem_ready) w_next = (r_class == CL_LDUR) ? ST_WB : ST_FETCH;
      ST_WB:     w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Strobes are suppressed while rst is high so a ready arriving in the reset
  // cycle can never commit a PC update or memory access.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        ST_EXEC: begin
          case (r_class)
            CL_B:    begin pc_write = 1'b1; pc_src = 1'b1;      end
            CL_CBZ:  begin pc_write = 1'b1; pc_src = alu_zero;  end
            CL_CBNZ: begin pc_write = 1'b1; pc_src = ~alu_zero; end
            default: ;
          endcase
        end
        ST_MEM: begin
          dmem_read  = (r_class == CL_LDUR);
          dmem_write = (r_class == CL_STUR);
          pc_write   = (r_class == CL_STUR) && dmem_ready;
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = r_illegal;
  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer: an instruction-level model
// queues the expected per-cycle outputs, a negedge monitor compares them.
module tb_pc_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int K_B = 0, K_CBZ = 1, K_CBNZ = 2, K_LD = 3, K_ST = 4, K_RT = 5, K_ILL = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [10:0]      opcode = '0;
  logic             alu_zero = 1'b0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             imem_req, ir_write, pc_write, pc_src;
  logic             dmem_read, dmem_write, reg_write, illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  pc_sequencer #(.CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .reg_write(reg_write),
    .illegal(illegal), .state(state), .retired(retired)
  );

  int          checks = 0;
  int          errors = 0;
  logic [14:0] exp_q[$];
  string       tag_q[$];
  int          nxt_st = -1;
  bit          exp_ill = 1'b0;
  int          exp_ret = 0;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] rop();
    return 11'($urandom);
  endfunction

  function automatic int classify(logic [10:0] op);
    int v = int'(op);
    if (v >= 'h0A0 && v <= 'h0BF) return K_B;
    if (v >= 'h5A0 && v <= 'h5A7) return K_CBZ;
    if (v >= 'h5A8 && v <= 'h5AF) return K_CBNZ;
    if (v == 'h7C2) return K_LD;
    if (v == 'h7C0) return K_ST;
    if (v == 'h458 || v == 'h658 || v == 'h450 || v == 'h550) return K_RT;
    return K_ILL;
  endfunction

  // strb order: {imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write, reg_write}
  task automatic step(input bit r, input bit im, input bit dm, input bit az,
                      input logic [10:0] op, input int st, input logic [6:0] strb,
                      input string tag);
    rst = r; imem_ready = im; dmem_ready = dm; alu_zero = az; opcode = op;
    if (st >= 0) begin
      exp_q.push_back({3'(st), strb, exp_ill, 4'(exp_ret)});
      tag_q.push_back(tag);
    end
    if (strb[4]) exp_ret = (exp_ret + 1) % 16;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input bit force_ready);
    for (int i = 0; i < n; i++) begin
      step(1'b1, force_ready | rb(), force_ready | rb(), rb(), rop(),
           (i == 0) ? nxt_st : 0, 7'b0, "reset");
      exp_ill = 1'b0;
      exp_ret = 0;
    end
    nxt_st = 0;
  endtask

  task automatic trap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rb(), rb(), rb(), rop(), 7, 7'b0, "trap");
  endtask

  task automatic run_instr(input logic [10:0] op, input int fw, input int mw,
                           input bit az, input bit abort);
    string t;
    int    k;
    t = $sformatf("op%03h", op);
    for (int i = 0; i < fw; i++)
      step(1'b0, 1'b0, rb(), rb(), rop(), 0, 7'b1000000, {t, " fetch-wait"});
    step(1'b0, 1'b1, rb(), rb(), rop(), 0, 7'b1100000, {t, " fetch"});
    step(1'b0, rb(), rb(), rb(), op, 1, 7'b0, {t, " decode"});
    k = classify(op);
    if (k == K_ILL) begin
      exp_ill = 1'b1;
      nxt_st = 7;
      return;
    end
    case (k)
      K_B:    step(1'b0, rb(), rb(), rb(), op, 2, 7'b0011000, {t, " exec"});
      K_CBZ:  step(1'b0, rb(), rb(), az, op, 2, {3'b001, az, 3'b000}, {t, " exec"});
      K_CBNZ: step(1'b0, rb(), rb(), az, op, 2, {3'b001, ~az, 3'b000}, {t, " exec"});
      default: step(1'b0, rb(), rb(), rb(), op, 2, 7'b0, {t, " exec"});
    endcase
    nxt_st = 0;
    if (k == K_RT) step(1'b0, rb(), rb(), rb(), op, 4, 7'b0010001, {t, " wb"});
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < mw; i++)
        step(1'b0, rb(), 1'b0, rb(), op, 3, (k == K_LD) ? 7'b0000100 : 7'b0000010,
             {t, " mem-wait"});
      if (abort) begin
        nxt_st = 3;
        do_reset(1 + $urandom_range(0, 1), 1'b1);
        return;
      end
      if (k == K_LD) begin
        step(1'b0, rb(), 1'b1, rb(), op, 3, 7'b0000100, {t, " mem"});
        step(1'b0, rb(), rb(), rb(), op, 4, 7'b0010001, {t, " wb"});
      end else begin
        step(1'b0, rb(), 1'b1, rb(), op, 3, 7'b0010010, {t, " mem"});
      end
    end
  endtask

  always @(negedge clk) begin
    logic [14:0] e;
    logic [14:0] a;
    string       t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {state, imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write,
           reg_write, illegal, retired};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d strb=%b ill=%b ret=%0d, expected st=%0d strb=%b ill=%b ret=%0d",
                 t, a[14:12], a[11:5], a[4], a[3:0], e[14:12], e[11:5], e[4], e[3:0]);
      end
    end
  end

  initial begin
    logic [10:0] op;
    int          k;
    logic [10:0] rtypes [4];
    rtypes[0] = 11'h458; rtypes[1] = 11'h658; rtypes[2] = 11'h450; rtypes[3] = 11'h550;

    do_reset(2, 1'b0);
    run_instr(11'h0A0, 0, 0, 1'b0, 1'b0);
    run_instr(11'h5A0, 0, 0, 1'b1, 1'b0);
    run_instr(11'h5A0, 0, 0, 1'b0, 1'b0);
    run_instr(11'h7C2, 0, 3, 1'b0, 1'b0);
    while (exp_ret != 15) run_instr(11'h0A0, 0, 0, 1'b0, 1'b0);
    run_instr(11'h458, 0, 0, 1'b0, 1'b0);
    run_instr(11'h0B5, 0, 0, 1'b0, 1'b0);
    run_instr(11'h7FF, 0, 0, 1'b0, 1'b0);
    trap(10);
    do_reset(1, 1'b1);
    run_instr(11'h7C0, 0, 1, 1'b0, 1'b1);
    run_instr(11'h7C0, 1, 2, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 6);
      case (k)
        K_B:    op = 11'(32'h0A0 + $urandom_range(0, 31));
        K_CBZ:  op = 11'(32'h5A0 + $urandom_range(0, 7));
        K_CBNZ: op = 11'(32'h5A8 + $urandom_range(0, 7));
        K_LD:   op = 11'h7C2;
        K_ST:   op = 11'h7C0;
        K_RT:   op = rtypes[$urandom_range(0, 3)];
        default: begin
          op = rop();
          while (classify(op) != K_ILL) op = rop();
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb(),
                ($urandom_range(0, 7) == 0));
      if (nxt_st == 7) begin
        trap($urandom_range(1, 4));
        do_reset($urandom_range(1, 2), rb());
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
